// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Sequences the PLL reset and derives the system reset from PLL lock. Runs
//   on the board reference clock, which also feeds the PLL. The PLL is held in
//   reset for a fixed time. The lock indication is then qualified for a
//   programmable stable window before sys_rst is released. A lock timeout, or
//   loss of lock while running, starts a new PLL reset attempt.
//
// Optional feature macro: PLL_LOCK_LOSS_CNT_EN
//   Defined   : loss_cnt counts RUN->PLL_RESET lock losses and saturates at 255.
//   Undefined : the counter is not built and loss_cnt reads 0.
//
// Ports
//   refclk     in   board clock (only clock)
//   rst        in   synchronous active-high reset
//   locked     in   PLL locked, asynchronous to refclk
//   pll_rst    out  PLL reset, active-high, registered
//   sys_rst    out  system reset, active-high, registered
//   ready      out  high only in RUN (== ~sys_rst)
//   retry_cnt  out  lock-timeout retries, saturates at 15
//   loss_cnt   out  lock losses in RUN (macro build), else 0
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 4096,
  parameter int unsigned STABLE_CYCLES  = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PR_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic             retry_inc;

  // 2-FF synchroniser for the asynchronous lock. It is deliberately left out
  // of reset so that lock history survives a push-button reset.
  logic [1:0] lk_pipe;
  logic       lk_s;

  always_ff @(posedge refclk) begin
    lk_pipe <= {lk_pipe[0], locked};
  end

  assign lk_s = lk_pipe[1];

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    retry_inc = 1'b0;
    case (state)
      PLL_RESET: begin
        if (timer == PR_LAST) begin
          timer_nxt = '0;
          state_nxt = WAIT_LOCK;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (lk_s) begin
          timer_nxt = '0;
          state_nxt = STABLE;
        end else if (timer == LT_LAST) begin
          retry_inc = 1'b1;
          timer_nxt = '0;
          state_nxt = PLL_RESET;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      STABLE: begin
        // Any drop in lock restarts both qualification and the lock timeout.
        if (!lk_s) begin
          timer_nxt = '0;
          state_nxt = WAIT_LOCK;
        end else if (timer == ST_LAST) begin
          timer_nxt = '0;
          state_nxt = RUN;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      RUN: begin
        if (!lk_s) begin
          timer_nxt = '0;
          state_nxt = PLL_RESET;
        end
      end
      default: begin
        timer_nxt = '0;
        state_nxt = PLL_RESET;
      end
    endcase
  end

  // The outputs are decoded from the next state. They are then registered, so
  // each output changes on the same edge as the state it reflects.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= PLL_RESET;
      timer     <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      pll_rst <= (state_nxt == PLL_RESET);
      sys_rst <= (state_nxt != RUN);
      ready   <= (state_nxt == RUN);
      if (retry_inc && (retry_cnt != 4'hF)) retry_cnt <= retry_cnt + 4'd1;
    end
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic loss_evt;
  assign loss_evt = (state == RUN) && !lk_s;

  always_ff @(posedge refclk) begin
    if (rst)                              loss_cnt <= '0;
    else if (loss_evt && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
  end
`else
  assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor. Expected values are pushed when
// stimulus is applied and popped when the matching DUT behaviour is measured.
// Outputs are sampled 1ns after each rising refclk edge, and inputs change at
// that same point.
module tb_pll_lock_supervisor;
  localparam int PR = 16;
  localparam int LT = 32;
  localparam int ST = 64;

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b1;
  logic       pll_rst, sys_rst, ready;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  typedef struct {string nm; int v;} exp_t;
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #10 refclk = ~refclk;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(PR), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(ST), .CNT_W(16)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .pll_rst(pll_rst),
    .sys_rst(sys_rst), .ready(ready), .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  task automatic step();
    @(posedge refclk); #1;
  endtask

  task automatic sb_push(string nm, int v);
    exp_t e;
    e.nm = nm; e.v = v;
    sb.push_back(e);
  endtask

  // Sample after the final rst-high edge is the reference edge 0.
  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got[$];
    exp_t e;
    locked = 1'b1;
    do_reset(3);
    sb_push("rst_pll_rst", 1); sb_push("rst_sys_rst", 1); sb_push("rst_ready", 0);
    sb_push("rst_retry", 0);   sb_push("rst_loss", 0);
    got = '{32'(pll_rst), 32'(sys_rst), 32'(ready), 32'(retry_cnt), 32'(loss_cnt)};
    foreach (got[i]) begin
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL sb_underflow got=%0d", got[i]); end
      else begin
        e = sb.pop_front();
        if (got[i] !== 32'(e.v)) begin bad++; $display("FAIL %s got=%0d exp=%0d", e.nm, got[i], e.v); end
      end
    end
  endtask

  task automatic test_power_up();
    logic [31:0] got[$];
    exp_t e;
    int edges = 0, pr = 0, rerr = 0;
    sb_push("pu_pll_rst_len", PR);
    sb_push("pu_release_edge", PR + 1 + ST);
    sb_push("pu_ready_err", 0);
    while (sys_rst !== 1'b0 && edges < 1000) begin
      if (pll_rst === 1'b1) pr++;
      if (ready !== ~sys_rst) rerr++;
      step(); edges++;
    end
    if (ready !== ~sys_rst) rerr++;
    got = '{32'(pr), 32'(edges), 32'(rerr)};
    foreach (got[i]) begin
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL sb_underflow got=%0d", got[i]); end
      else begin
        e = sb.pop_front();
        if (got[i] !== 32'(e.v)) begin bad++; $display("FAIL %s got=%0d exp=%0d", e.nm, got[i], e.v); end
      end
    end
  endtask

  task automatic test_stable_glitch();
    logic [31:0] got[$];
    exp_t e;
    int a = 17 + 30;
    int edges = 0, pr = 0;
    locked = 1'b1;
    do_reset(1);
    sb_push("sg_pll_rst_len", PR);
    sb_push("sg_release_edge", a + 4 + ST);
    while (sys_rst !== 1'b0 && edges < 1000) begin
      if (pll_rst === 1'b1) pr++;
      if (edges == a)     locked = 1'b0;
      if (edges == a + 1) locked = 1'b1;
      step(); edges++;
    end
    got = '{32'(pr), 32'(edges)};
    foreach (got[i]) begin
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL sb_underflow got=%0d", got[i]); end
      else begin
        e = sb.pop_front();
        if (got[i] !== 32'(e.v)) begin bad++; $display("FAIL %s got=%0d exp=%0d", e.nm, got[i], e.v); end
      end
    end
  endtask

  task automatic test_run_loss();
    logic [31:0] got[$];
    exp_t e;
    int edges = 0, pr = 0, rise = -1, rerr = 0;
    locked = 1'b0;
    sb_push("rl_sys_rst_rise", 3);
    sb_push("rl_pll_rst_len", PR);
    sb_push("rl_release_edge", 20 + ST);
    sb_push("rl_ready_err", 0);
`ifdef PLL_LOCK_LOSS_CNT_EN
    sb_push("rl_loss_cnt", 1);
`else
    sb_push("rl_loss_cnt", 0);
`endif
    sb_push("rl_retry_cnt", 0);
    while (!(rise >= 0 && sys_rst === 1'b0) && edges < 1000) begin
      if (edges == 5) locked = 1'b1;
      step(); edges++;
      if (rise < 0 && sys_rst === 1'b1) rise = edges;
      if (pll_rst === 1'b1) pr++;
      if (ready !== ~sys_rst) rerr++;
    end
    got = '{32'(rise), 32'(pr), 32'(edges), 32'(rerr), 32'(loss_cnt), 32'(retry_cnt)};
    foreach (got[i]) begin
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL sb_underflow got=%0d", got[i]); end
      else begin
        e = sb.pop_front();
        if (got[i] !== 32'(e.v)) begin bad++; $display("FAIL %s got=%0d exp=%0d", e.nm, got[i], e.v); end
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] got[$];
    exp_t e;
    // Mid-RUN: a single rst cycle restores every reset value.
    rst = 1'b1; step();
    got = '{32'(pll_rst), 32'(sys_rst), 32'(ready), 32'(retry_cnt), 32'(loss_cnt)};
    rst = 1'b0;
    sb_push("mr_pll_rst", 1); sb_push("mr_sys_rst", 1); sb_push("mr_ready", 0);
    sb_push("mr_retry", 0);   sb_push("mr_loss", 0);
    // Mid-WAIT_LOCK after one timeout.
    locked = 1'b0;
    do_reset(3);
    repeat (PR + LT + PR + 10) step();
    got.push_back(32'(retry_cnt)); got.push_back(32'(pll_rst)); got.push_back(32'(sys_rst));
    sb_push("mw_retry_before", 1); sb_push("mw_pll_rst_before", 0); sb_push("mw_sys_rst_before", 1);
    rst = 1'b1; step();
    got.push_back(32'(pll_rst)); got.push_back(32'(sys_rst)); got.push_back(32'(ready));
    got.push_back(32'(retry_cnt)); got.push_back(32'(loss_cnt));
    rst = 1'b0;
    sb_push("mw_pll_rst", 1); sb_push("mw_sys_rst", 1); sb_push("mw_ready", 0);
    sb_push("mw_retry", 0);   sb_push("mw_loss", 0);
    foreach (got[i]) begin
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL sb_underflow got=%0d", got[i]); end
      else begin
        e = sb.pop_front();
        if (got[i] !== 32'(e.v)) begin bad++; $display("FAIL %s got=%0d exp=%0d", e.nm, got[i], e.v); end
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    logic        prev;
    logic [31:0] o;
    int edges = 0, hi_start = 0;
    bit seen = 0;
    locked = 1'b0;
    do_reset(3);
    for (int k = 1; k <= 16; k++) begin
      sb_push("to_rise_edge", k * (PR + LT));
      sb_push("to_retry", (k > 15) ? 15 : k);
      sb_push("to_pulse_len", PR);
    end
    repeat (16 * (PR + LT) + 24) begin
      prev = pll_rst;
      step(); edges++;
      if (pll_rst === 1'b1 && prev === 1'b0) begin
        hi_start = edges; seen = 1;
        for (int j = 0; j < 2; j++) begin
          o = (j == 0) ? 32'(edges) : 32'(retry_cnt);
          total++;
          if (sb.size() == 0) begin bad++; $display("FAIL sb_underflow got=%0d", o); end
          else begin
            e = sb.pop_front();
            if (o !== 32'(e.v)) begin bad++; $display("FAIL %s got=%0d exp=%0d", e.nm, o, e.v); end
          end
        end
      end
      if (pll_rst === 1'b0 && prev === 1'b1 && seen) begin
        o = 32'(edges - hi_start);
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL sb_underflow got=%0d", o); end
        else begin
          e = sb.pop_front();
          if (o !== 32'(e.v)) begin bad++; $display("FAIL %s got=%0d exp=%0d", e.nm, o, e.v); end
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL to_events_missing got=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

`ifdef PLL_LOCK_LOSS_CNT_EN
  task automatic test_loss_sat();
    exp_t e;
    logic [31:0] o;
    int n, expired = 0;
    locked = 1'b1;
    do_reset(3);
    n = 0;
    while (sys_rst !== 1'b0 && n < 400) begin step(); n++; end
    if (n >= 400) expired++;
    sb_push("ls_loss_100", 100); sb_push("ls_loss_255", 255); sb_push("ls_loss_300", 255);
    for (int i = 1; i <= 300; i++) begin
      locked = 1'b0;
      repeat (5) step();
      locked = 1'b1;
      n = 0;
      while (sys_rst !== 1'b0 && n < 400) begin step(); n++; end
      if (n >= 400) expired++;
      if (i == 100 || i == 255 || i == 300) begin
        o = 32'(loss_cnt);
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL sb_underflow got=%0d", o); end
        else begin
          e = sb.pop_front();
          if (o !== 32'(e.v)) begin bad++; $display("FAIL %s got=%0d exp=%0d", e.nm, o, e.v); end
        end
      end
    end
    total++;
    if (expired != 0) begin bad++; $display("FAIL ls_relock_bound got=%0d exp=0", expired); end
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_up();
    test_stable_glitch();
    test_run_loss();
    test_rst_mid();
    test_timeout();
`ifdef PLL_LOCK_LOSS_CNT_EN
    test_loss_sat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
